conv_kxk_stream: RTL and testbench
==================================

CONV_KXK_STREAM -- requirements
Module: conv_kxk_stream

Interface
REQ-001 Parameter DW, default 16: signed pixel, weight and output width.
REQ-002 Parameter IMG_W, default 96: input image width in pixels.
REQ-003 Parameter IMG_H, default 96: input image height in pixels.
REQ-004 Parameter K, default 9: square kernel size, legal range 1..11, with K<=IMG_W and K<=IMG_H.
REQ-005 Parameter FRAC, default 12: fractional bits of the weights; legal range 1..DW-1.
REQ-006 Parameter BIAS, default -3953: signed DW-bit bias, added after scaling.
REQ-007 clk_in  in  1  clock; all logic is on the rising edge.
REQ-008 rst_n  in  1  reset; synchronous, active-low.
REQ-009 pix_in  in  DW  signed input pixel, raster order.
REQ-010 pix_valid  in  1  pix_in is accepted on every cycle in which this is high.
REQ-011 w_we  in  1  weight write strobe.
REQ-012 w_addr  in  7  weight index, row*K+col; values >= K*K are ignored.
REQ-013 w_data  in  DW  signed weight.
REQ-014 out_data  out  DW  signed convolution result.
REQ-015 out_valid  out  1  out_data is valid this cycle.
REQ-016 frame_done  out  1  one-cycle pulse, coincident with the last out_valid of a frame.
REQ-017 busy  out  1  high from the first accepted pixel of a frame until frame_done.

Function
REQ-018 The block SHALL keep the weights in K*K registers, and SHALL write w_data to weight[w_addr] only when w_we=1, busy=0 and w_addr<K*K.
REQ-019 The block SHALL hold K-1 line buffers of IMG_W entries and a KxK window register array, and SHALL shift both only on accepted pixels.
REQ-020 Column counter col and row counter row SHALL advance per accepted pixel, with col wrapping at IMG_W-1 and row wrapping at IMG_H-1.
REQ-021 After the last pixel of a frame, both counters SHALL return to 0 and the next frame SHALL start without any idle cycle.
REQ-022 An accepted pixel SHALL complete a window when row>=K-1 and col>=K-1, giving exactly (IMG_W-K+1)*(IMG_H-K+1) outputs per frame.
REQ-023 The pipeline SHALL be 3 stages: (1) K*K registered products, (2) registered per-row sums, (3) total, round, bias, clamp into out_data.
REQ-024 Latency SHALL be 3 cycles: out_valid rises exactly 3 clk_in cycles after the accepting edge of the window-completing pixel.
REQ-025 The pipeline SHALL advance every cycle regardless of pix_valid; a valid tag travels with each stage.
REQ-026 The accumulator SHALL be 2*DW+ceil(log2(K*K)) bits wide and SHALL never overflow.
REQ-027 Rounding SHALL be half-up: (acc + 2^(FRAC-1)) arithmetic-shifted right by FRAC, followed by adding BIAS.
REQ-028 The result SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-029 When out_valid=0, out_data SHALL hold its previous value.
REQ-030 frame_done SHALL assert for exactly one cycle per frame; busy SHALL fall in the cycle after frame_done, or stay high if the next frame has already started.
REQ-031 When a weight write and an accepted pixel occur in the same cycle while busy=0, the pixel SHALL be processed with the old weights and the write SHALL take effect on the next cycle.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL clear col, row, all valid tags, out_data, out_valid, frame_done and busy to 0.
REQ-033 Reset SHALL also clear all weights and window registers to 0; line-buffer contents need not be cleared.
REQ-034 A reset mid-frame SHALL discard the partial frame; the next accepted pixel after reset SHALL be treated as pixel (0,0).

Configuration
REQ-035 With macro CONV_KXK_RELU_EN defined, any negative saturated result SHALL be output as 0.
REQ-036 Without CONV_KXK_RELU_EN, signed saturated results SHALL be output unchanged.

Verification
REQ-037 Config K=3, IMG_W=IMG_H=5, FRAC=12, BIAS=0, all weights 4096, pix_in=1 continuous -> 9 outputs of 9, and a single frame_done on the 9th output.
REQ-038 Same config, only weight[4]=2048, pix_in=3 -> outputs 2; with pix_in=-3 -> outputs -1 (half-up rounding).
REQ-039 Same config, all weights 32767, pix_in=32767 -> outputs 32767; with pix_in=-32768 -> outputs -32768, or 0 when CONV_KXK_RELU_EN is defined.
REQ-040 Scenario REQ-037 repeated with pix_valid toggling 1,0,1,0... -> identical output values and count, each output exactly 3 cycles after its completing pixel.
REQ-041 rst_n=0 for 1 cycle after 12 pixels, then weights reloaded and 25 pixels sent -> out_valid=0 the cycle after reset, then exactly 9 outputs and one frame_done.
REQ-042 Two frames back-to-back -> 18 outputs, 2 frame_done pulses, busy held high between frames; w_we during busy -> weights unchanged.

Source files
------------

// File: rtl/conv_kxk_stream.sv
// ---------------------------------------------------------------------------
// conv_kxk_stream
//
// Streaming KxK 2-D convolution over a raster-ordered image of IMG_W x IMG_H
// signed pixels. K-1 line buffers plus a KxK window register array form the
// sliding window. A 3-stage pipeline computes each output: (1) K*K products,
// (2) per-row sums, (3) total, half-up rounding, bias and saturation.
// Every window-completing pixel produces exactly one result, 3 cycles after
// the clock edge that accepted it.
//
// Optional feature: define CONV_KXK_RELU_EN to clamp negative results to 0.
//
// Ports
//   clk_in      clock, rising edge
//   rst_n       synchronous active-low reset
//   pix_in      signed input pixel (raster order)
//   pix_valid   pix_in is accepted on every cycle this is high
//   w_we        weight write strobe (honoured only while busy=0)
//   w_addr      weight index row*K+col; indices >= K*K are ignored
//   w_data      signed weight, FRAC fractional bits
//   out_data    signed result, held while out_valid=0
//   out_valid   out_data carries a new result this cycle
//   frame_done  one-cycle pulse on the last out_valid of a frame
//   busy        high from the first accepted pixel of a frame to frame_done
//
// Handshake: there is no back-pressure. A pixel is consumed on every rising
// edge where pix_valid=1; results appear with out_valid=1 for one cycle each
// and must be taken by the consumer in that cycle.
// ---------------------------------------------------------------------------
module conv_kxk_stream #(
  parameter int DW    = 16,
  parameter int IMG_W = 96,
  parameter int IMG_H = 96,
  parameter int K     = 9,
  parameter int FRAC  = 12,
  parameter int BIAS  = -3953
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] pix_in,
  input  logic                 pix_valid,
  input  logic                 w_we,
  input  logic [6:0]           w_addr,
  input  logic signed [DW-1:0] w_data,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int KK  = K * K;
  localparam int AW  = 2 * DW + $clog2(KK);          // accumulator width
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WAW = (KK > 1) ? $clog2(KK) : 1;
  localparam int LBN = (K > 1) ? K - 1 : 1;           // line buffer count (>=1 for legality)

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

  localparam longint RND_L = longint'(1) << (FRAC - 1);
  localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Position counters
  // -------------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          win_done;
  logic          frame_last;

  assign win_done   = (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
  assign frame_last = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Weights. A write that lands in the same cycle as an accepted pixel is
  // parked for one cycle so the products of that pixel (formed on the next
  // edge) still see the old weight set.
  // -------------------------------------------------------------------------
  logic signed [DW-1:0] weight [KK];
  logic                 w_ok;
  logic                 wr_pend;
  logic [WAW-1:0]       wr_addr_q;
  logic signed [DW-1:0] wr_data_q;

  assign w_ok = w_we && !busy && (int'(w_addr) < KK);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int i = 0; i < KK; i++) weight[i] <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= w_ok && pix_valid;
      if (w_ok && pix_valid) begin
        wr_addr_q <= w_addr[WAW-1:0];
        wr_data_q <= w_data;
      end else if (w_ok) begin
        weight[w_addr[WAW-1:0]] <= w_data;
      end
      // A parked write implies busy=1 now, so it never collides with w_ok.
      if (wr_pend) weight[wr_addr_q] <= wr_data_q;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers: circular per column. line_buf[0] holds the previous row,
  // line_buf[i] the row i+1 above the current one.
  // -------------------------------------------------------------------------
  logic signed [DW-1:0] line_buf [LBN][IMG_W];
  logic signed [DW-1:0] new_col  [K];

  always_ff @(posedge clk_in) begin
    if (pix_valid) begin
      line_buf[0][col] <= pix_in;
      for (int i = 1; i < K - 1; i++) line_buf[i][col] <= line_buf[i-1][col];
    end
  end

  // Incoming window column, top (oldest row) at index 0, new pixel at K-1.
  always_comb begin
    for (int r = 0; r < K; r++) new_col[r] = '0;
    new_col[K-1] = pix_in;
    for (int i = 1; i < K; i++) new_col[K-1-i] = line_buf[i-1][col];
  end

  // -------------------------------------------------------------------------
  // Window register array: shifts left by one column per accepted pixel.
  // -------------------------------------------------------------------------
  logic signed [DW-1:0] win [K][K];

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (pix_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= new_col[r];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Valid / last-of-frame tags. Tag 0 marks a freshly completed window; the
  // pipeline behind it advances every cycle.
  // -------------------------------------------------------------------------
  logic v0, v1, v2;
  logic l0, l1, l2;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
      l0 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0;
    end else begin
      v0 <= pix_valid && win_done;
      l0 <= pix_valid && frame_last;
      v1 <= v0;
      l1 <= l0;
      v2 <= v1;
      l2 <= l1;
    end
  end

  // Stage 1: products
  logic signed [2*DW-1:0] prod [K][K];

  always_ff @(posedge clk_in) begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) prod[r][c] <= win[r][c] * weight[r*K+c];
  end

  // Stage 2: per-row sums
  logic signed [AW-1:0] row_sum_c [K];
  logic signed [AW-1:0] row_sum   [K];

  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_sum_c[r] = '0;
      for (int c = 0; c < K; c++) row_sum_c[r] = row_sum_c[r] + AW'(prod[r][c]);
    end
  end

  always_ff @(posedge clk_in) begin
    for (int r = 0; r < K; r++) row_sum[r] <= row_sum_c[r];
  end

  // Stage 3: total, half-up round, bias, saturate (and optional ReLU)
  logic signed [AW-1:0]   total_c;
  logic signed [AW:0]     rnd_sum;
  logic signed [AW:0]     shifted;
  logic signed [AW+1:0]   biased;
  logic signed [DW-1:0]   sat_c;
  logic signed [DW-1:0]   res_c;

  always_comb begin
    total_c = '0;
    for (int r = 0; r < K; r++) total_c = total_c + row_sum[r];
    // One extra bit so adding the rounding constant cannot wrap.
    rnd_sum = (AW+1)'(total_c) + (AW+1)'(RND_L);
    shifted = rnd_sum >>> FRAC;
    biased  = (AW+2)'(shifted) + (AW+2)'(BIAS);
    if (biased > (AW+2)'(OUT_MAX))      sat_c = OUT_MAX;
    else if (biased < (AW+2)'(OUT_MIN)) sat_c = OUT_MIN;
    else                                sat_c = biased[DW-1:0];
`ifdef CONV_KXK_RELU_EN
    res_c = sat_c[DW-1] ? '0 : sat_c;
`else
    res_c = sat_c;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= v2;
      frame_done <= v2 && l2;
      if (v2) out_data <= res_c;
    end
  end

  // -------------------------------------------------------------------------
  // busy: counters sitting at (0,0) when frame_done is seen means no pixel of
  // the next frame has arrived yet, so the block can go idle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else if (pix_valid) begin
      busy <= 1'b1;
    end else if (frame_done && (col == '0) && (row == '0)) begin
      busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// ---------------------------------------------------------------------------
// tb_conv_kxk_stream
//
// Directed testbench for conv_kxk_stream with K=3, 5x5 image, FRAC=12,
// BIAS=0. Expected values are hand-computed constants; output timing is
// predicted from the bench's own raster position tracking.
// ---------------------------------------------------------------------------
module tb_conv_kxk_stream;

  localparam int DW    = 16;
  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
  localparam int K     = 3;
  localparam int FRAC  = 12;
  localparam int BIAS  = 0;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = (IMG_W - K + 1) * (IMG_H - K + 1);

  logic                 clk_in    = 1'b0;
  logic                 rst_n     = 1'b0;
  logic signed [DW-1:0] pix_in    = '0;
  logic                 pix_valid = 1'b0;
  logic                 w_we      = 1'b0;
  logic [6:0]           w_addr    = '0;
  logic signed [DW-1:0] w_data    = '0;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 frame_done;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic signed [DW-1:0] obs_q[$];
  int                   obs_cyc[$];
  int                   exp_cyc[$];
  int                   fd_idx[$];
  int                   fd_cnt = 0;
  int                   tb_row = 0;
  int                   tb_col = 0;

  conv_kxk_stream #(
    .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .FRAC(FRAC), .BIAS(BIAS)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_done(frame_done),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- output capture ----------------
  always @(negedge clk_in) begin
    if (out_valid) begin
      obs_q.push_back(out_data);
      obs_cyc.push_back(cyc);
      if (frame_done) fd_idx.push_back(obs_q.size());
    end
    if (frame_done) fd_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    exp_cyc.delete();
    fd_idx.delete();
    fd_cnt = 0;
  endtask

  task automatic drive_pixel(input logic signed [DW-1:0] val, input logic we,
                             input logic [6:0] addr, input logic signed [DW-1:0] data);
    @(negedge clk_in);
    pix_valid = 1'b1;
    pix_in    = val;
    w_we      = we;
    w_addr    = addr;
    w_data    = data;
    // Accepted on the next edge (cyc+1); result sampled 3 edges later.
    if (tb_row >= K - 1 && tb_col >= K - 1) exp_cyc.push_back(cyc + 4);
    if (tb_col == IMG_W - 1) begin
      tb_col = 0;
      tb_row = (tb_row == IMG_H - 1) ? 0 : tb_row + 1;
    end else begin
      tb_col = tb_col + 1;
    end
  endtask

  task automatic idle();
    @(negedge clk_in);
    pix_valid = 1'b0;
    w_we      = 1'b0;
  endtask

  task automatic write_w(input int addr, input int data);
    @(negedge clk_in);
    pix_valid = 1'b0;
    w_we      = 1'b1;
    w_addr    = 7'(addr);
    w_data    = DW'(data);
    @(negedge clk_in);
    w_we      = 1'b0;
  endtask

  task automatic set_all(input int data);
    for (int i = 0; i < K * K; i++) write_w(i, data);
  endtask

  task automatic run_frame(input int val, input bit gap);
    for (int i = 0; i < NPIX; i++) begin
      drive_pixel(DW'(val), 1'b0, 7'd0, '0);
      if (gap) idle();
    end
    idle();
    repeat (5) @(negedge clk_in);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++;
    if ({out_valid, frame_done, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {out_valid, frame_done, busy});
    end
    checks++;
    if (out_data !== 16'sd0) begin
      failures++;
      $display("FAIL reset_data: got %0d expected 0", out_data);
    end
    rst_n = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({out_valid, frame_done, busy} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_flags: got %b expected 000", {out_valid, frame_done, busy});
    end
  endtask

  task automatic test_ones();
    int got;
    set_all(4096);
    write_w(9, 16'sh7fff);     // out of range: must be ignored
    write_w(100, -1);          // out of range: must be ignored
    clear_obs();
    run_frame(1, 1'b0);
    checks++;
    if (obs_q.size() != NOUT) begin
      failures++;
      $display("FAIL ones_count: got %0d expected %0d", obs_q.size(), NOUT);
    end
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 9) begin
        failures++;
        $display("FAIL ones_value[%0d]: got %0d expected 9", i, got);
      end
    end
    checks++;
    if (fd_cnt != 1 || (fd_idx.size() == 1 ? fd_idx[0] : -1) != NOUT) begin
      failures++;
      $display("FAIL ones_frame_done: got pulses=%0d at_output=%0d expected 1 at %0d",
               fd_cnt, (fd_idx.size() > 0 ? fd_idx[0] : -1), NOUT);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ones_busy_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_rounding();
    int got;
    int exp_neg;
`ifdef CONV_KXK_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -1;
`endif
    set_all(0);
    write_w(4, 2048);
    clear_obs();
    run_frame(3, 1'b0);
    checks++;
    if (obs_q.size() != NOUT) begin
      failures++;
      $display("FAIL round_pos_count: got %0d expected %0d", obs_q.size(), NOUT);
    end
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 2) begin
        failures++;
        $display("FAIL round_pos[%0d]: got %0d expected 2", i, got);
      end
    end
    clear_obs();
    run_frame(-3, 1'b0);
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != exp_neg) begin
        failures++;
        $display("FAIL round_neg[%0d]: got %0d expected %0d", i, got, exp_neg);
      end
    end
  endtask

  task automatic test_saturation();
    int got;
    int exp_neg;
`ifdef CONV_KXK_RELU_EN
    exp_neg = 0;
`else
    exp_neg = -32768;
`endif
    set_all(32767);
    clear_obs();
    run_frame(32767, 1'b0);
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 32767) begin
        failures++;
        $display("FAIL sat_pos[%0d]: got %0d expected 32767", i, got);
      end
    end
    clear_obs();
    run_frame(-32768, 1'b0);
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != exp_neg) begin
        failures++;
        $display("FAIL sat_neg[%0d]: got %0d expected %0d", i, got, exp_neg);
      end
    end
  endtask

  task automatic test_toggle();
    int got;
    int got_c;
    set_all(4096);
    clear_obs();
    run_frame(1, 1'b1);
    checks++;
    if (obs_q.size() != NOUT || exp_cyc.size() != NOUT) begin
      failures++;
      $display("FAIL toggle_count: got %0d expected %0d (predicted %0d)",
               obs_q.size(), NOUT, exp_cyc.size());
    end
    for (int i = 0; i < NOUT; i++) begin
      got   = (i < obs_q.size())   ? int'(obs_q[i]) : -99999;
      got_c = (i < obs_cyc.size()) ? obs_cyc[i]     : -1;
      checks++;
      if (got != 9) begin
        failures++;
        $display("FAIL toggle_value[%0d]: got %0d expected 9", i, got);
      end
      checks++;
      if (i >= exp_cyc.size() || got_c != exp_cyc[i]) begin
        failures++;
        $display("FAIL toggle_latency[%0d]: got cycle %0d expected %0d", i, got_c,
                 (i < exp_cyc.size() ? exp_cyc[i] : -1));
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      failures++;
      $display("FAIL toggle_frame_done: got %0d expected 1", fd_cnt);
    end
  endtask

  task automatic test_write_with_pixel();
    int got;
    // Centre weight goes 4096 -> 8192 with the first pixel; later windows see it.
    clear_obs();
    drive_pixel(16'sd1, 1'b1, 7'd4, 16'sd8192);
    for (int i = 1; i < NPIX; i++) drive_pixel(16'sd1, 1'b0, 7'd0, '0);
    idle();
    repeat (5) @(negedge clk_in);
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 10) begin
        failures++;
        $display("FAIL wr_with_pix[%0d]: got %0d expected 10", i, got);
      end
    end
    write_w(4, 4096);
  endtask

  task automatic test_back_to_back();
    int got;
    int bad_busy;
    bad_busy = 0;
    clear_obs();
    for (int i = 0; i < 2 * NPIX; i++) begin
      // Write attempt while busy must be dropped.
      if (i == 10) drive_pixel(16'sd1, 1'b1, 7'd4, 16'sd0);
      else         drive_pixel(16'sd1, 1'b0, 7'd0, '0);
      if (i > 0 && busy !== 1'b1) bad_busy++;
    end
    idle();
    repeat (3) begin
      if (busy !== 1'b1) bad_busy++;
      @(negedge clk_in);
    end
    if (busy !== 1'b1) bad_busy++;
    @(negedge clk_in);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_fall: got %b expected 0", busy);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL b2b_busy_held: got %0d low samples expected 0", bad_busy);
    end
    checks++;
    if (obs_q.size() != 2 * NOUT) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), 2 * NOUT);
    end
    for (int i = 0; i < 2 * NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 9) begin
        failures++;
        $display("FAIL b2b_value[%0d]: got %0d expected 9", i, got);
      end
    end
    checks++;
    if (fd_cnt != 2 || fd_idx.size() != 2 ||
        (fd_idx.size() == 2 ? (fd_idx[0] != NOUT || fd_idx[1] != 2 * NOUT) : 1'b1)) begin
      failures++;
      $display("FAIL b2b_frame_done: got pulses=%0d tagged=%0d expected 2 at %0d,%0d",
               fd_cnt, fd_idx.size(), NOUT, 2 * NOUT);
    end
  endtask

  task automatic test_mid_reset();
    int got;
    clear_obs();
    for (int i = 0; i < 12; i++) drive_pixel(16'sd5, 1'b0, 7'd0, '0);
    @(negedge clk_in);
    pix_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_flags: got valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    tb_row = 0;
    tb_col = 0;
    // Weights were cleared by reset: an unloaded frame gives all zeros.
    clear_obs();
    run_frame(1, 1'b0);
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 0) begin
        failures++;
        $display("FAIL mid_reset_wclr[%0d]: got %0d expected 0", i, got);
      end
    end
    set_all(4096);
    clear_obs();
    run_frame(1, 1'b0);
    checks++;
    if (obs_q.size() != NOUT) begin
      failures++;
      $display("FAIL mid_reset_count: got %0d expected %0d", obs_q.size(), NOUT);
    end
    for (int i = 0; i < NOUT; i++) begin
      got = (i < obs_q.size()) ? int'(obs_q[i]) : -99999;
      checks++;
      if (got != 9) begin
        failures++;
        $display("FAIL mid_reset_value[%0d]: got %0d expected 9", i, got);
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      failures++;
      $display("FAIL mid_reset_frame_done: got %0d expected 1", fd_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ones();
    test_rounding();
    test_saturation();
    test_toggle();
    test_write_with_pixel();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
